// File: rtl/accel_motion_detector.sv
// Boxcar-averages X/Y/Z accelerometer samples taken every SAMPLE_DIV cycles, then
// reports the dominant tilt, a debounced shake pulse and a tone select derived from them.
module accel_motion_detector #(
  parameter int SAMPLE_DIV = 1048576,
  parameter int AVG_LOG2   = 2,
  parameter int TILT_THR   = 4096,
  parameter int SHAKE_THR  = 6000,
  parameter int SHAKE_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] y_i,
  input  logic signed [15:0] z_i,
  output logic signed [15:0] x_avg_o,
  output logic signed [15:0] y_avg_o,
  output logic signed [15:0] z_avg_o,
  output logic               avg_valid_o,
  output logic [2:0]         tilt_dir_o,
  output logic               shake_pulse_o,
  output logic [3:0]         tone_sel_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;
  localparam int CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int LW    = (SHAKE_HOLD > 0) ? $clog2(SHAKE_HOLD + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_ACCUM   = 3'd2;
  localparam logic [2:0] S_OUTPUT  = 3'd3;
  localparam logic [2:0] S_DETECT  = 3'd4;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tick;
  logic [2:0]           state_q, state_d;

  logic signed [15:0]   smp_q  [3];
  logic signed [15:0]   ring_q [3][DEPTH];
  logic signed [SW-1:0] sum_q  [3];
  logic signed [SW-1:0] sum_d  [3];
  logic signed [15:0]   avg_d  [3];
  logic signed [15:0]   avg_q  [3];
  logic signed [15:0]   prev_q [3];
  logic [AVG_LOG2-1:0]  ptr_q;
  logic [AVG_LOG2:0]    fill_q, fill_d;
  logic                 prev_valid_q;
  logic [LW-1:0]        lock_q;

  logic                 avg_valid_q;
  logic [2:0]           tilt_q;
  logic                 shake_q;
  logic [3:0]           tone_q;

  logic [16:0]          abs_a [3];
  logic [16:0]          dif_a [3];
  logic [18:0]          shake_mag;
  logic [16:0]          dom_abs;
  logic [2:0]           dom_code;
  logic [2:0]           tilt_d;
  logic                 shake_hit;

  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic signed [16:0] e;
    e = {v[15], v};
    return e[16] ? -e : e;
  endfunction

  function automatic logic [16:0] absdiff17(input logic signed [15:0] a,
                                            input logic signed [15:0] b);
    logic signed [16:0] dd;
    dd = {a[15], a} - {b[15], b};
    return dd[16] ? -dd : dd;
  endfunction

  assign tick = en_i && (cnt_q == CW'(SAMPLE_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || tick) cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tick) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACCUM;
      S_ACCUM:   state_d = S_OUTPUT;
      S_OUTPUT:  state_d = (fill_q == (AVG_LOG2 + 1)'(DEPTH)) ? S_DETECT : S_IDLE;
      S_DETECT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Running sum: add the newest sample and drop the one it overwrites in the ring.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      sum_d[a] = sum_q[a] + $signed({{AVG_LOG2{smp_q[a][15]}}, smp_q[a]})
                          - $signed({{AVG_LOG2{ring_q[a][ptr_q][15]}}, ring_q[a][ptr_q]});
      avg_d[a] = 16'(sum_d[a] >>> AVG_LOG2);
    end
    fill_d = (fill_q == (AVG_LOG2 + 1)'(DEPTH)) ? fill_q : fill_q + 1'b1;
  end

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      abs_a[a] = abs17(avg_q[a]);
      dif_a[a] = absdiff17(avg_q[a], prev_q[a]);
    end
    shake_mag = {2'b00, dif_a[0]} + {2'b00, dif_a[1]} + {2'b00, dif_a[2]};

    // Ties favour X over Y over Z.
    if (abs_a[0] >= abs_a[1] && abs_a[0] >= abs_a[2]) begin
      dom_abs  = abs_a[0];
      dom_code = avg_q[0][15] ? 3'd2 : 3'd1;
    end else if (abs_a[1] >= abs_a[2]) begin
      dom_abs  = abs_a[1];
      dom_code = avg_q[1][15] ? 3'd4 : 3'd3;
    end else begin
      dom_abs  = abs_a[2];
      dom_code = avg_q[2][15] ? 3'd6 : 3'd5;
    end
    tilt_d    = (dom_abs < 17'(TILT_THR)) ? 3'd0 : dom_code;
    shake_hit = prev_valid_q && (shake_mag >= 19'(SHAKE_THR)) && (lock_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      fill_q       <= '0;
      prev_valid_q <= 1'b0;
      lock_q       <= '0;
      avg_valid_q  <= 1'b0;
      tilt_q       <= '0;
      shake_q      <= 1'b0;
      tone_q       <= '0;
      for (int a = 0; a < 3; a++) begin
        smp_q[a]  <= '0;
        sum_q[a]  <= '0;
        avg_q[a]  <= '0;
        prev_q[a] <= '0;
        for (int i = 0; i < DEPTH; i++) ring_q[a][i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      avg_valid_q <= 1'b0;
      shake_q     <= 1'b0;
      case (state_q)
        S_CAPTURE: begin
          smp_q[0] <= x_i;
          smp_q[1] <= y_i;
          smp_q[2] <= z_i;
        end
        S_ACCUM: begin
          for (int a = 0; a < 3; a++) begin
            sum_q[a]         <= sum_d[a];
            ring_q[a][ptr_q] <= smp_q[a];
          end
          ptr_q  <= ptr_q + 1'b1;
          fill_q <= fill_d;
          // Averages land as the FSM enters OUTPUT, so avg_valid is high in that state.
          if (fill_d == (AVG_LOG2 + 1)'(DEPTH)) begin
            for (int a = 0; a < 3; a++) avg_q[a] <= avg_d[a];
            avg_valid_q <= 1'b1;
          end
        end
        S_DETECT: begin
          tilt_q  <= tilt_d;
          shake_q <= shake_hit;
          tone_q  <= shake_hit ? 4'hF : {1'b0, tilt_d};
          if (shake_hit)           lock_q <= LW'(SHAKE_HOLD);
          else if (lock_q != '0)   lock_q <= lock_q - 1'b1;
          for (int a = 0; a < 3; a++) prev_q[a] <= avg_q[a];
          prev_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x_avg_o       = avg_q[0];
  assign y_avg_o       = avg_q[1];
  assign z_avg_o       = avg_q[2];
  assign avg_valid_o   = avg_valid_q;
  assign tilt_dir_o    = tilt_q;
  assign shake_pulse_o = shake_q;
  assign tone_sel_o    = tone_q;

endmodule
